// File: rtl/dcache_refill_ctrl.sv
// Miss handler between the 2-way data cache and main memory: single-word read refill,
// write-through stores with no allocation, and a saturating read-miss counter.
module dcache_refill_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rd_en_i,
  input  logic                     wr_en_i,
  input  logic                     miss_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic                     stall_o,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     rdata_valid_o,
  output logic                     fill_we_o,
  output logic [ADDRESS_WIDTH-1:0] fill_addr_o,
  output logic [DATA_WIDTH-1:0]    fill_data_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  input  logic                     mem_ready_i,
  output logic [CNT_WIDTH-1:0]     miss_count_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    FILL    = 3'd2,
    WR_WAIT = 3'd3,
    WR_DONE = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_aligned;
  logic                     cnt_saturated;

  assign addr_aligned  = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign cnt_saturated = &cnt_q;

  // Load data is kept separate from store data so rdata_o keeps its last refill across stores.
  assign rdata_o      = rdata_q;
  assign miss_count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    stall_o       = 1'b0;
    rdata_valid_o = 1'b0;
    fill_we_o     = 1'b0;
    fill_addr_o   = '0;
    fill_data_o   = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;

    unique case (state_q)
      IDLE: begin
        // Stores win over loads; miss_i only matters for a load.
        if (wr_en_i) begin
          stall_o = 1'b1;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          state_d = WR_WAIT;
        end else if (rd_en_i && miss_i) begin
          stall_o = 1'b1;
          addr_d  = addr_i;
          if (!cnt_saturated) begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = addr_aligned;
        if (mem_ready_i) begin
          rdata_d = mem_rdata_i;
          state_d = FILL;
        end
      end

      FILL: begin
        // The missing load is still in MEM this cycle and completes from rdata_o.
        fill_we_o     = 1'b1;
        fill_addr_o   = addr_q;
        fill_data_o   = rdata_q;
        rdata_valid_o = 1'b1;
        state_d       = IDLE;
      end

      WR_WAIT: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_aligned;
        mem_wdata_o = wdata_q;
        if (mem_ready_i) begin
          state_d = WR_DONE;
        end
      end

      WR_DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
